// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch-decode-execute controller for the accumulator CPU.
// It generates every register write strobe in the core (PC, MAR, IR, ACC)
// and runs the req/ack handshake to program memory.
//
// Optional feature: define SEQ_TIMEOUT_EN to add a memory-wait timeout.
// With it, a wait state that sees no ack for TMO cycles moves to FAULT.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for run
// F_ADDR | MAR <- PC
// F_MEM  | instruction read; ack loads IR and increments PC
// DECODE | dispatch on opcode; jumps load PC from the IR operand
// E_ADDR | MAR <- IR operand
// E_MEM  | operand read (LDA/ADD) or ACC write (STA)
// HALT   | terminal after HLT, left only by reset
// FAULT  | terminal after illegal opcode or timeout, left only by reset
module cpu_sequencer #(
    parameter int n   = 8,
    parameter int TMO = 15
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       acc_zero,
    input  logic       mem_ack,
    output logic       pc_inc,
    output logic       pc_we,
    output logic       mar_we,
    output logic       mar_sel,
    output logic       ir_we,
    output logic       acc_we,
    output logic       acc_sel,
    output logic       mem_req,
    output logic       mem_we,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_ADDR = 3'd1,
        F_MEM  = 3'd2,
        DECODE = 3'd3,
        E_ADDR = 3'd4,
        E_MEM  = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_STA = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JZ  = 4'd5;
    localparam logic [3:0] OP_HLT = 4'd6;

    state_t r_state;
    state_t w_next;
    logic   w_wait;
    logic   w_tmo_hit;

    // The opcode field is fixed at 4 bits; the datapath width only sizes the
    // operand, which this controller never touches.
    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = 32'(n) ^ 32'(TMO);

    assign w_wait = (r_state == F_MEM) || (r_state == E_MEM);
    assign state  = r_state;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);

    logic [TW-1:0] r_tmo;

    // Timeout fires only when the terminal count is reached with no ack;
    // an ack in that same cycle wins.
    assign w_tmo_hit = w_wait && !mem_ack && (r_tmo == TW'(TMO));

    // Wait-cycle counter: counts un-acked wait cycles, zero everywhere else
    // so it is already clear on entry to a wait state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_tmo <= '0;
        end else if (w_wait && !mem_ack && !w_tmo_hit) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // State register; reset drops every state-decoded output at once.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobes; ack-qualified strobes are combinational on mem_ack.
    always_comb begin
        w_next  = r_state;
        pc_inc  = 1'b0;
        pc_we   = 1'b0;
        mar_we  = 1'b0;
        mar_sel = 1'b0;
        ir_we   = 1'b0;
        acc_we  = 1'b0;
        acc_sel = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;

        case (r_state)
            IDLE: begin
                if (run) begin
                    w_next = F_ADDR;
                end
            end
            F_ADDR: begin
                mar_we = 1'b1;
                w_next = F_MEM;
            end
            F_MEM: begin
                if (w_tmo_hit) begin
                    w_next = FAULT;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we  = 1'b1;
                        pc_inc = 1'b1;
                        w_next = DECODE;
                    end
                end
            end
            DECODE: begin
                case (opcode)
                    OP_NOP: w_next = F_ADDR;
                    OP_LDA, OP_STA, OP_ADD: w_next = E_ADDR;
                    OP_JMP: begin
                        pc_we  = 1'b1;
                        w_next = F_ADDR;
                    end
                    OP_JZ: begin
                        pc_we  = acc_zero;
                        w_next = F_ADDR;
                    end
                    OP_HLT: w_next = HALT;
                    default: w_next = FAULT;
                endcase
            end
            E_ADDR: begin
                mar_we  = 1'b1;
                mar_sel = 1'b1;
                w_next  = E_MEM;
            end
            E_MEM: begin
                if (w_tmo_hit) begin
                    w_next = FAULT;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (opcode == OP_STA);
                    if (mem_ack) begin
                        if (opcode == OP_LDA) begin
                            acc_we = 1'b1;
                        end else if (opcode == OP_ADD) begin
                            acc_we  = 1'b1;
                            acc_sel = 1'b1;
                        end
                        w_next = F_ADDR;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer. Inputs change on the falling edge and
// outputs are compared 1 ns later, as a packed vector of strobes + state.
module tb_cpu_sequencer;

    logic       clk;
    logic       clr_n;
    logic       run;
    logic [3:0] opcode;
    logic       acc_zero;
    logic       mem_ack;
    logic       pc_inc, pc_we, mar_we, mar_sel, ir_we, acc_we, acc_sel;
    logic       mem_req, mem_we, halted, fault;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] NONE = 11'h000;
    localparam logic [10:0] PCI  = 11'h400;
    localparam logic [10:0] PCW  = 11'h200;
    localparam logic [10:0] MARW = 11'h100;
    localparam logic [10:0] MARS = 11'h080;
    localparam logic [10:0] IRW  = 11'h040;
    localparam logic [10:0] ACCW = 11'h020;
    localparam logic [10:0] ACCS = 11'h010;
    localparam logic [10:0] REQ  = 11'h008;
    localparam logic [10:0] MWE  = 11'h004;
    localparam logic [10:0] HLTD = 11'h002;
    localparam logic [10:0] FLT  = 11'h001;

    logic [13:0] w_obs;
    assign w_obs = {pc_inc, pc_we, mar_we, mar_sel, ir_we, acc_we, acc_sel,
                    mem_req, mem_we, halted, fault, state};

    cpu_sequencer #(.n(8), .TMO(15)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .run      (run),
        .opcode   (opcode),
        .acc_zero (acc_zero),
        .mem_ack  (mem_ack),
        .pc_inc   (pc_inc),
        .pc_we    (pc_we),
        .mar_we   (mar_we),
        .mar_sel  (mar_sel),
        .ir_we    (ir_we),
        .acc_we   (acc_we),
        .acc_sel  (acc_sel),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .halted   (halted),
        .fault    (fault),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [3:0] op,
                        input logic ack, input logic az,
                        input logic [10:0] s, input logic [2:0] st);
        @(negedge clk);
        run      = r;
        opcode   = op;
        mem_ack  = ack;
        acc_zero = az;
        #1;
        chk(tag, w_obs, {s, st});
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        clr_n   = 1'b0;
        run     = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk(tag, w_obs, 14'h0000);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n    = 1'b0;
        run      = 1'b0;
        opcode   = 4'h0;
        acc_zero = 1'b0;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", w_obs, 14'h0000);
        @(negedge clk);
        clr_n = 1'b1;

        // NOP loop, zero-wait memory
        step("idle_no_run",  0, 4'h0, 0, 0, NONE, 3'd0);
        step("idle_run",     1, 4'h0, 0, 0, NONE, 3'd0);
        step("nop_faddr",    0, 4'h0, 1, 0, MARW, 3'd1);
        step("nop_fmem",     0, 4'h0, 1, 0, PCI | IRW | REQ, 3'd2);
        step("nop_decode",   0, 4'h0, 1, 0, NONE, 3'd3);
        step("nop_faddr2",   0, 4'h0, 0, 0, MARW, 3'd1);

        // LDA 0xA
        step("lda_fmem",     0, 4'h1, 1, 0, PCI | IRW | REQ, 3'd2);
        step("lda_decode",   0, 4'h1, 0, 0, NONE, 3'd3);
        step("lda_eaddr",    0, 4'h1, 0, 0, MARW | MARS, 3'd4);
        step("lda_emem",     0, 4'h1, 1, 0, REQ | ACCW, 3'd5);
        step("lda_faddr",    0, 4'h1, 0, 0, MARW, 3'd1);

        // ADD
        step("add_fmem",     0, 4'h3, 1, 0, PCI | IRW | REQ, 3'd2);
        step("add_decode",   0, 4'h3, 0, 0, NONE, 3'd3);
        step("add_eaddr",    0, 4'h3, 0, 0, MARW | MARS, 3'd4);
        step("add_emem",     0, 4'h3, 1, 0, REQ | ACCW | ACCS, 3'd5);
        step("add_faddr",    0, 4'h3, 0, 0, MARW, 3'd1);

        // JZ taken, then not taken
        step("jz1_fmem",     0, 4'h5, 1, 1, PCI | IRW | REQ, 3'd2);
        step("jz1_decode",   0, 4'h5, 0, 1, PCW, 3'd3);
        step("jz1_faddr",    0, 4'h5, 1, 1, MARW, 3'd1);
        step("jz0_fmem",     0, 4'h5, 1, 0, PCI | IRW | REQ, 3'd2);
        step("jz0_decode",   0, 4'h5, 0, 0, NONE, 3'd3);
        step("jz0_faddr",    0, 4'h5, 0, 0, MARW, 3'd1);

        // JMP
        step("jmp_fmem",     0, 4'h4, 1, 0, PCI | IRW | REQ, 3'd2);
        step("jmp_decode",   0, 4'h4, 0, 0, PCW, 3'd3);
        step("jmp_faddr",    0, 4'h4, 0, 0, MARW, 3'd1);

        // STA with a one-cycle fetch wait and a three-cycle operand wait
        step("sta_fwait",    0, 4'h2, 0, 0, REQ, 3'd2);
        step("sta_fmem",     0, 4'h2, 1, 0, PCI | IRW | REQ, 3'd2);
        step("sta_decode",   0, 4'h2, 0, 0, NONE, 3'd3);
        step("sta_eaddr",    0, 4'h2, 0, 0, MARW | MARS, 3'd4);
        for (int i = 0; i < 3; i++)
            step("sta_ewait", 0, 4'h2, 0, 0, REQ | MWE, 3'd5);
        step("sta_eack",     0, 4'h2, 1, 0, REQ | MWE, 3'd5);
        step("sta_req_drop", 0, 4'h2, 0, 0, MARW, 3'd1);

`ifndef SEQ_TIMEOUT_EN
        // Without the timeout a long wait simply holds
        for (int i = 0; i < 20; i++)
            step("long_wait", 0, 4'h0, 0, 0, REQ, 3'd2);
        step("long_ack",     0, 4'h0, 1, 0, PCI | IRW | REQ, 3'd2);
        step("long_decode",  0, 4'h0, 0, 0, NONE, 3'd3);
        step("long_faddr",   0, 4'h0, 0, 0, MARW, 3'd1);
`endif

        // HLT, then run toggling must not leave HALT
        step("hlt_fmem",     0, 4'h6, 1, 0, PCI | IRW | REQ, 3'd2);
        step("hlt_decode",   0, 4'h6, 0, 0, NONE, 3'd3);
        for (int i = 0; i < 10; i++)
            step("hlt_hold", logic'(i % 2 == 0), 4'h6, logic'(i % 3 == 0), 0, HLTD, 3'd6);
        reset_pulse("hlt_reset");

        // Illegal opcode 0xF
        step("ill_idle",     1, 4'hF, 0, 0, NONE, 3'd0);
        step("ill_faddr",    0, 4'hF, 0, 0, MARW, 3'd1);
        step("ill_fmem",     0, 4'hF, 1, 0, PCI | IRW | REQ, 3'd2);
        step("ill_decode",   0, 4'hF, 0, 0, NONE, 3'd3);
        step("ill_fault",    1, 4'hF, 1, 0, FLT, 3'd7);
        step("ill_fault2",   0, 4'h0, 0, 0, FLT, 3'd7);
        reset_pulse("fault_reset");

        // Reset in the middle of a handshake drops mem_req asynchronously
        step("mid_idle",     1, 4'h0, 0, 0, NONE, 3'd0);
        step("mid_faddr",    0, 4'h0, 0, 0, MARW, 3'd1);
        step("mid_fmem",     0, 4'h0, 0, 0, REQ, 3'd2);
        clr_n = 1'b0;
        #1;
        chk("mid_async_drop", w_obs, 14'h0000);
        @(negedge clk);
        clr_n = 1'b1;
        step("mid_after",    0, 4'h0, 1, 0, NONE, 3'd0);

`ifdef SEQ_TIMEOUT_EN
        // No ack: 15 wait cycles, then the timeout cycle, then FAULT
        step("tmo_idle",     1, 4'h0, 0, 0, NONE, 3'd0);
        step("tmo_faddr",    0, 4'h0, 0, 0, MARW, 3'd1);
        for (int i = 0; i < 15; i++)
            step("tmo_wait", 0, 4'h0, 0, 0, REQ, 3'd2);
        step("tmo_hit",      0, 4'h0, 0, 0, NONE, 3'd2);
        step("tmo_fault",    0, 4'h0, 0, 0, FLT, 3'd7);
        reset_pulse("tmo_reset");

        // Ack on the terminal-count cycle wins
        step("tmo2_idle",    1, 4'h0, 0, 0, NONE, 3'd0);
        step("tmo2_faddr",   0, 4'h0, 0, 0, MARW, 3'd1);
        for (int i = 0; i < 15; i++)
            step("tmo2_wait", 0, 4'h0, 0, 0, REQ, 3'd2);
        step("tmo2_ack",     0, 4'h0, 1, 0, PCI | IRW | REQ, 3'd2);
        step("tmo2_decode",  0, 4'h0, 0, 0, NONE, 3'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
